ram_fifo_sync: RTL and testbench
================================

# ram_fifo_sync

Parametrised single-clock FIFO built on an inferred dual-port RAM. It generalises the fixed 32-bit hard-block FIFO mode to arbitrary data width and depth, with full-width programmable almost-empty/almost-full thresholds, a level output, and sticky overflow/underflow error flags. It sits between fabric producers and consumers wherever a buffered RAM FIFO is needed without the hard DPRAM_FIFO macro.

## Interface

- DATA_WIDTH, 32, word width in bits (>= 1)
- ADDR_WIDTH, 9, log2 of DEPTH; DEPTH = 2**ADDR_WIDTH words (ADDR_WIDTH >= 2)

- CLK  in  1  sole clock; all logic rising-edge
- RST_N  in  1  asynchronous, active-low reset (assert async, deassert sync externally)
- FFLUSH  in  1  synchronous flush, highest priority
- WEN  in  1  write request
- WDATA  in  DATA_WIDTH  write data
- REN  in  1  read request (pop)
- RDATA  out  DATA_WIDTH  read data
- UPAE  in  ADDR_WIDTH+1  almost-empty threshold
- UPAF  in  ADDR_WIDTH+1  almost-full threshold
- FFLAGS  out  4  [0] EMPTY, [1] AEMPTY, [2] AFULL, [3] FULL
- LEVEL  out  ADDR_WIDTH+1  words held
- OVERFLOW  out  1  sticky: write attempted while FULL
- UNDERFLOW  out  1  sticky: read attempted while EMPTY

## Operation

- Priority per edge: RST_N low > FFLUSH > REN/WEN.
- Write accepted iff WEN && !FULL; WDATA stored at wr_ptr, wr_ptr++.
- Read accepted iff REN && !EMPTY; rd_ptr++.
- Write while FULL: dropped, OVERFLOW set; simultaneous REN does not make room that cycle.
- Read while EMPTY: dropped, UNDERFLOW set, RDATA holds; simultaneous WEN does not bypass.
- Pointers are ADDR_WIDTH bits, wrap modulo DEPTH; LEVEL is a separate counter: +1 write only, -1 read only, unchanged both/neither.
- EMPTY = LEVEL==0; FULL = LEVEL==DEPTH; AEMPTY = LEVEL<=UPAE; AFULL = LEVEL>=UPAF; all combinational from registered LEVEL (UPAF=0 gives AFULL constant 1).
- FFLUSH: pointers, LEVEL, OVERFLOW, UNDERFLOW, output-valid cleared; WEN/REN that cycle ignored; RDATA and RAM contents retained.
- Reset values: RDATA=0, LEVEL=0, FFLAGS=4'b0011 when UPAE>=0 (EMPTY=1, AEMPTY=1, AFULL=(UPAF==0), FULL=0), OVERFLOW=0, UNDERFLOW=0.
- Reset mid-operation discards all words; no partial write completes.

## Timing

- Standard mode: accepted read at edge N -> RDATA valid after edge N, held until next accepted read.
- Write at edge N -> LEVEL/flags updated after edge N; same word readable by REN sampled at edge N+1.
- Flags and LEVEL change only on clock edges (or async reset), except AEMPTY/AFULL which also follow UPAE/UPAF combinationally.
- Sustained throughput: one write and one read per cycle.

## Configuration

- FIFO_FWFT_EN defined: first-word-fall-through. Head word is presented on RDATA with no REN; EMPTY=0 means RDATA is valid; REN pops and the next word appears after the same edge if present. Write into an empty FIFO at edge N -> EMPTY deasserts after edge N+2. LEVEL counts the output-stage word; capacity stays DEPTH.
- Undefined: standard mode as above; no output stage.

## Structure

- Package ram_fifo_pkg: flag bit index constants (FLAG_EMPTY=0, FLAG_AEMPTY=1, FLAG_AFULL=2, FLAG_FULL=3), DEPTH function of ADDR_WIDTH.
- Sub-module ram_dp_sync: storage array, one write port, one registered read port, no reset on the array; FIFO control stays in the top.

## Test plan

- Reset, DATA_WIDTH=8, ADDR_WIDTH=2, UPAE=1, UPAF=3 -> FFLAGS=4'b0011, LEVEL=0, RDATA=0.
- Write 0x11,0x22,0x33,0x44 -> LEVEL 1..4, AFULL at 3, FULL at 4; fifth write 0x55 -> dropped, OVERFLOW=1; four reads -> 0x11,0x22,0x33,0x44, each one cycle after REN.
- Read on empty -> UNDERFLOW=1, RDATA unchanged, LEVEL=0; FFLUSH -> both sticky flags cleared.
- Simultaneous WEN+REN at LEVEL=2 for 10 cycles across pointer wrap -> LEVEL stays 2, data order preserved.
- FFLUSH with WEN+REN high at LEVEL=3 -> LEVEL=0, EMPTY=1 next cycle, no write stored.
- FIFO_FWFT_EN: write 0xA5 into empty at edge N -> EMPTY=0 and RDATA=0xA5 after N+2 without REN; REN pops -> EMPTY=1.

Source files
------------

// File: rtl/ram_fifo_pkg.sv
// Shared constants for the RAM-based synchronous FIFO: flag bit positions and depth helper.
package ram_fifo_pkg;

  localparam int FLAG_EMPTY  = 0;
  localparam int FLAG_AEMPTY = 1;
  localparam int FLAG_AFULL  = 2;
  localparam int FLAG_FULL   = 3;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/ram_dp_sync.sv
// Simple dual-port RAM: one write port, one registered read port.
// Only the read register is reset; the array itself is left uninitialised.
module ram_dp_sync #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ram_fifo_sync.sv
// Parametrised single-clock FIFO on an inferred dual-port RAM with programmable thresholds.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is standard (pop-then-read).
module ram_fifo_sync
  import ram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  FFLUSH,
  input  logic                  WEN,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  REN,
  output logic [DATA_WIDTH-1:0] RDATA,
  input  logic [ADDR_WIDTH:0]   UPAE,
  input  logic [ADDR_WIDTH:0]   UPAF,
  output logic [3:0]            FFLAGS,
  output logic [ADDR_WIDTH:0]   LEVEL,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_L   = (ADDR_WIDTH+1)'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   level;
  logic                  empty, full, wr_acc, rd_acc, ram_re;

  assign full   = (level == DEPTH_L);
  assign wr_acc = WEN && !full && !FFLUSH;
  assign rd_acc = REN && !empty && !FFLUSH;

`ifdef FIFO_FWFT_EN
  // ram_cnt: words in the array not yet moved to the output register.
  // A word written on the previous edge is not prefetched yet, matching the hard FIFO latency.
  logic [ADDR_WIDTH:0] ram_cnt;
  logic                out_valid, wr_d;

  assign empty  = !out_valid;
  assign ram_re = !FFLUSH && (ram_cnt > {{ADDR_WIDTH{1'b0}}, wr_d}) && (!out_valid || rd_acc);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ram_cnt   <= '0;
      out_valid <= 1'b0;
      wr_d      <= 1'b0;
    end else if (FFLUSH) begin
      ram_cnt   <= '0;
      out_valid <= 1'b0;
      wr_d      <= 1'b0;
    end else begin
      wr_d <= wr_acc;
      case ({wr_acc, ram_re})
        2'b10:   ram_cnt <= ram_cnt + ONE_L;
        2'b01:   ram_cnt <= ram_cnt - ONE_L;
        default: ram_cnt <= ram_cnt;
      endcase
      if (ram_re)      out_valid <= 1'b1;
      else if (rd_acc) out_valid <= 1'b0;
    end
  end
`else
  assign empty  = (level == '0);
  assign ram_re = rd_acc;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else if (FFLUSH) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (ram_re) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   level <= level + ONE_L;
        2'b01:   level <= level - ONE_L;
        default: level <= level;
      endcase
      if (WEN && full)  OVERFLOW  <= 1'b1;
      if (REN && empty) UNDERFLOW <= 1'b1;
    end
  end

  ram_dp_sync #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (CLK),
    .rst_n (RST_N),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (WDATA),
    .re    (ram_re),
    .raddr (rd_ptr),
    .rdata (RDATA)
  );

  always_comb begin
    FFLAGS              = '0;
    FFLAGS[FLAG_EMPTY]  = empty;
    FFLAGS[FLAG_AEMPTY] = (level <= UPAE);
    FFLAGS[FLAG_AFULL]  = (level >= UPAF);
    FFLAGS[FLAG_FULL]   = full;
  end

  assign LEVEL = level;

endmodule

// File: tb/tb_ram_fifo_sync.sv
// Directed self-checking bench for ram_fifo_sync (DATA_WIDTH=8, ADDR_WIDTH=2).
module tb_ram_fifo_sync;

  logic       clk, rst_n, fflush, wen, ren;
  logic [7:0] wdata, rdata;
  logic [2:0] upae, upaf, level;
  logic [3:0] fflags;
  logic       overflow, underflow;

  int checks = 0;
  int fails  = 0;

  ram_fifo_sync #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .FFLUSH    (fflush),
    .WEN       (wen),
    .WDATA     (wdata),
    .REN       (ren),
    .RDATA     (rdata),
    .UPAE      (upae),
    .UPAF      (upaf),
    .FFLAGS    (fflags),
    .LEVEL     (level),
    .OVERFLOW  (overflow),
    .UNDERFLOW (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] wvals [4];
  logic [3:0] fl_after_wr [4];

  initial begin
    wvals[0] = 8'h11; wvals[1] = 8'h22; wvals[2] = 8'h33; wvals[3] = 8'h44;
    fl_after_wr[0] = 4'b0010; fl_after_wr[1] = 4'b0000;
    fl_after_wr[2] = 4'b0100; fl_after_wr[3] = 4'b1100;

    rst_n = 1'b0; fflush = 1'b0; wen = 1'b0; ren = 1'b0; wdata = '0;
    upae = 3'd1; upaf = 3'd3;
    repeat (3) cyc();
    chk("rst_fflags", fflags, 4'b0011);
    chk("rst_level",  level,  0);
    chk("rst_rdata",  rdata,  0);
    chk("rst_ovf",    overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

`ifdef FIFO_FWFT_EN
    wen = 1'b1; wdata = 8'hA5;
    cyc();
    wen = 1'b0;
    chk("fwft_empty_n",  fflags[0], 1);
    chk("fwft_level_n",  level, 1);
    cyc();
    chk("fwft_empty_n1", fflags[0], 1);
    cyc();
    chk("fwft_empty_n2", fflags[0], 0);
    chk("fwft_rdata_n2", rdata, 8'hA5);
    ren = 1'b1;
    cyc();
    ren = 1'b0;
    chk("fwft_pop_empty", fflags[0], 1);
    chk("fwft_pop_level", level, 0);
    chk("fwft_pop_udf",   underflow, 0);
`else
    for (int i = 0; i < 4; i++) begin
      wen = 1'b1; wdata = wvals[i];
      cyc();
      chk($sformatf("wr%0d_level", i), level, i + 1);
      chk($sformatf("wr%0d_flags", i), fflags, fl_after_wr[i]);
    end
    wdata = 8'h55;
    cyc();
    wen = 1'b0;
    chk("ovf_set",   overflow, 1);
    chk("ovf_level", level, 4);

    ren = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("rd%0d_data", i), rdata, wvals[i]);
      chk($sformatf("rd%0d_level", i), level, 3 - i);
    end
    chk("drained_flags", fflags, 4'b0011);

    cyc();
    ren = 1'b0;
    chk("udf_set",   underflow, 1);
    chk("udf_rdata", rdata, 8'h44);
    chk("udf_level", level, 0);

    fflush = 1'b1;
    cyc();
    fflush = 1'b0;
    chk("flush_ovf",   overflow, 0);
    chk("flush_udf",   underflow, 0);
    chk("flush_rdata", rdata, 8'h44);

    wen = 1'b1;
    wdata = 8'hA0; cyc();
    wdata = 8'hA1; cyc();
    ren = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wdata = 8'(8'hA2 + i);
      cyc();
      chk($sformatf("wrap%0d_data", i), rdata, 8'(8'hA0 + i));
      chk($sformatf("wrap%0d_level", i), level, 2);
    end
    ren = 1'b0;
    wdata = 8'hAC; cyc();
    chk("pre_flush_level", level, 3);

    fflush = 1'b1; ren = 1'b1; wdata = 8'hEE;
    cyc();
    fflush = 1'b0; ren = 1'b0;
    chk("flush_level", level, 0);
    chk("flush_flags", fflags, 4'b0011);
    chk("flush_keep_rdata", rdata, 8'hA9);

    wdata = 8'h77; cyc();
    wen = 1'b0;
    chk("post_flush_level", level, 1);
    ren = 1'b1; cyc(); ren = 1'b0;
    chk("post_flush_data", rdata, 8'h77);

    wen = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wdata = 8'(i);
      cyc();
    end
    chk("full_again", fflags[3], 1);
    ren = 1'b1; wdata = 8'h99;
    cyc();
    wen = 1'b0;
    chk("full_wr_rd_ovf",   overflow, 1);
    chk("full_wr_rd_level", level, 3);
    chk("full_wr_rd_data",  rdata, 8'h01);
    for (int i = 2; i <= 4; i++) begin
      cyc();
      chk($sformatf("tail%0d_data", i), rdata, 8'(i));
    end
    ren = 1'b0;
    chk("tail_level", level, 0);

    upaf = 3'd0;
    #1;
    chk("upaf0_afull", fflags[2], 1);
    upae = 3'd0; upaf = 3'd4;
    #1;
    chk("upae0_aempty", fflags[1], 1);
    chk("upaf4_afull",  fflags[2], 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
